sfx_tone_gen: RTL
=================

Name: sfx_tone_gen

Overview:
- Downstream consumer of the player beat counter's 8-bit beat index.
- Maps each beat to a tone period, synthesises a 16-bit square-wave sample, and serialises it to the board's I2S audio DAC (MCLK/LRCK/SCK/SDIN).
- Provides the audio path for the game sound effects (paddle hit, score jingle).

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; the tone table is computed for this value.
- NUM_BEATS, 8, number of valid table entries; ibeat >= NUM_BEATS plays silence.
- AMPLITUDE, 16'h4000, peak square-wave magnitude at full volume.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- en  in  1  sound enable; 0 forces silence.
- ibeat  in  8  beat index from the beat counter.
- volume  in  3  0 mutes; 7 is full scale.
- audio_mclk  out  1  DAC master clock, clk/4.
- audio_lrck  out  1  frame select: 0 = left, 1 = right.
- audio_sck  out  1  serial bit clock, clk/16.
- audio_sdin  out  1  serial data, MSB first.
- tone_active  out  1  1 while a non-silent tone is selected.

Behaviour:
- Reset (reset=0, asynchronous): all counters 0, sample_hold 0, every output 0.
- Tone table (tone_div, clk cycles per period) by beat 0..7: 191204, 151685, 127551, 95602, 127551, 151685, 191204, 0.
  - div 0 means silence.
  - The table is a combinational lookup on ibeat.
- Effective divider: div_eff = (en && ibeat < NUM_BEATS) ? tone_div : 0.
- tone_active is registered and equals (div_eff != 0), one clk after ibeat/en change.
- Tone counter (22-bit tone_cnt):
  - Increments every clk; wraps to 0 when tone_cnt >= div_eff-1.
  - Forced to 0 while div_eff == 0.
  - Forced to 0 on the clk after div_eff changes, so each beat starts at phase 0.
- Amplitude: amp = (volume == 0) ? 0 : AMPLITUDE >> (7 - volume).
- Sample (signed 16-bit):
  - div_eff == 0: sample = 0.
  - Otherwise sample = +amp when tone_cnt < div_eff>>1, else -amp (two's complement).
- Frame counter (9-bit fcnt): free-running, wraps 511 -> 0.
  - mclk = fcnt[1], sck = fcnt[3], lrck = fcnt[8].
  - 16 bits per channel, 32 per frame, frame rate about 195.3 kHz.
- Sample hold: sample_hold <= sample when fcnt == 511. Both channels of a frame carry the same held value, so the value is stable for a whole frame.
- Serial data: sdin = sample_hold[15 - fcnt[7:4]].
  - Changes only while sck is low; stable across every sck rising edge.
- Output registration: all audio_* outputs are registered copies of the above. Each output lags fcnt by exactly 1 clk.
- Boundary conditions:
  - ibeat jumps mid-tone: new period takes effect next clk, phase restarts.
  - en drops mid-frame: the current frame still plays the held sample; the next frame is 0.
  - reset asserted mid-frame: outputs go 0 immediately. After release, fcnt restarts at 0 with lrck=0 and sample_hold=0, so the first frame is silent.
  - volume changes: take effect at the next sample_hold update only.

Decomposition:
- Package sfx_pkg holds:
  - TONE_DIV table array and its width constant (22).
  - FRAME_BITS=9 and SAMPLE_W=16.
  - Helper function tone_div_lookup(ibeat).
- Natural sub-module i2s_serializer: owns fcnt, sample_hold and the four audio_* outputs. Inputs: clk, reset, sample[15:0].
- The top level holds the table lookup, tone_cnt and amplitude scaling.

Test Plan:
- Reset: hold reset=0 for 5 clk -> all outputs 0. Release -> audio_mclk first rises at clk 3, audio_sck at clk 9, audio_lrck at clk 257.
- Tone: en=1, ibeat=3, volume=7 -> sample = +16'h4000 for 47801 clk, then 16'hC000 for 47801 clk; sdin of the following frame shifts out 0100_0000_0000_0000 MSB first on both channels.
- Silence: ibeat=7, or ibeat=9, or en=0 -> tone_active=0 one clk later; every sdin bit is 0 from the next full frame on.
- Volume: volume=4 at ibeat=0 -> held sample = 16'h0800 / 16'hF800. volume=0 -> 0.
- Beat change mid-period: ibeat 0 -> 1 at tone_cnt=50000 -> tone_cnt reads 0 on the next clk; the new period is 151685.
- Async reset mid-frame: assert reset at fcnt=300 -> outputs go 0 without a clk edge. After release, the first full frame is all-zero.

Source files
------------

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared constants, types and helpers for the sound-effect tone generator.
//   - TONE_DIV: clk cycles per square-wave period for beats 0..7 at 100 MHz
//   - tone_div_lookup(): table lookup with out-of-range beats mapped to silence
//   - scale_tone_table(): rescales the table to a different system clock
package sfx_pkg;

  localparam int     DIV_W      = 22;
  localparam int     FRAME_BITS = 9;
  localparam int     SAMPLE_W   = 16;
  localparam int     NUM_TONES  = 8;
  localparam int     BEAT_IDX_W = 3;
  localparam longint REF_CLK_HZ = 100_000_000;

  typedef logic [NUM_TONES-1:0][DIV_W-1:0] tone_table_t;

  // Listed from entry 7 down to entry 0; a divider of 0 means silence.
  localparam tone_table_t TONE_DIV = {
    22'd0,      22'd191204, 22'd151685, 22'd127551,
    22'd95602,  22'd127551, 22'd151685, 22'd191204
  };

  function automatic logic [DIV_W-1:0] tone_div_lookup(input logic [7:0] beat);
    logic [DIV_W-1:0] div;
    div = '0;
    if (beat < 8'(NUM_TONES)) begin
      div = TONE_DIV[beat[BEAT_IDX_W-1:0]];
    end
    return div;
  endfunction

  // Elaboration-time only: the periods were tuned for REF_CLK_HZ, so a
  // different clock scales every entry proportionally to keep the pitches.
  function automatic tone_table_t scale_tone_table(input longint clk_hz);
    tone_table_t table_out;
    for (int i = 0; i < NUM_TONES; i++) begin
      table_out[i] = DIV_W'((longint'(tone_div_lookup(8'(i))) * clk_hz) / REF_CLK_HZ);
    end
    return table_out;
  endfunction

endpackage

// File: rtl/sfx_tone_gen_if.sv
// sfx_tone_gen_if: control inputs and I2S/status outputs of the tone generator.
//   en, ibeat, volume           : driven by the game logic (master)
//   audio_mclk/lrck/sck/sdin    : I2S DAC pins, driven by the generator (slave)
//   tone_active                 : high while a non-silent tone is selected
interface sfx_tone_gen_if;
  logic       en;
  logic [7:0] ibeat;
  logic [2:0] volume;
  logic       audio_mclk;
  logic       audio_lrck;
  logic       audio_sck;
  logic       audio_sdin;
  logic       tone_active;

  modport master (
    output en, ibeat, volume,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin, tone_active
  );

  modport slave (
    input  en, ibeat, volume,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin, tone_active
  );
endinterface

// File: rtl/i2s_serializer.sv
// i2s_serializer: free-running 512-clk I2S frame generator.
//   clk, reset (async, active-low)
//   sample      : signed 16-bit sample, captured once per frame
//   audio_mclk  : clk/4      audio_sck : clk/16
//   audio_lrck  : 0 = left half, 1 = right half of the frame
//   audio_sdin  : held sample, MSB first, same value on both channels
module i2s_serializer
  import sfx_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin
);

  logic [FRAME_BITS-1:0] fcnt_q, fcnt_d;
  logic [SAMPLE_W-1:0]   sample_hold_q, sample_hold_d;
  logic mclk_q, mclk_d, lrck_q, lrck_d, sck_q, sck_d, sdin_q, sdin_d;

  // The sample is latched on the last count of a frame so the whole next
  // frame (both channels) shifts out one stable value. Every pin is a
  // registered copy of the current count, so all of them lag fcnt by one clk
  // and sdin only moves while sck is low.
  always_comb begin
    fcnt_d        = fcnt_q + FRAME_BITS'(1);
    sample_hold_d = (fcnt_q == '1) ? sample : sample_hold_q;
    mclk_d        = fcnt_q[1];
    sck_d         = fcnt_q[3];
    lrck_d        = fcnt_q[FRAME_BITS-1];
    sdin_d        = sample_hold_q[4'd15 - fcnt_q[7:4]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt_q        <= '0;
      sample_hold_q <= '0;
      mclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      sck_q         <= 1'b0;
      sdin_q        <= 1'b0;
    end else begin
      fcnt_q        <= fcnt_d;
      sample_hold_q <= sample_hold_d;
      mclk_q        <= mclk_d;
      lrck_q        <= lrck_d;
      sck_q         <= sck_d;
      sdin_q        <= sdin_d;
    end
  end

  assign audio_mclk = mclk_q;
  assign audio_lrck = lrck_q;
  assign audio_sck  = sck_q;
  assign audio_sdin = sdin_q;

endmodule

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: maps a beat index to a square-wave tone and streams it to
// the I2S DAC.
//   clk, reset (async, active-low)
//   bus.en, bus.ibeat, bus.volume     : tone selection and loudness
//   bus.audio_*                       : I2S pins (from i2s_serializer)
//   bus.tone_active                   : registered "non-silent tone selected"
module sfx_tone_gen
  import sfx_pkg::*;
#(
  parameter int                  CLK_HZ    = 100_000_000,
  parameter int                  NUM_BEATS = 8,
  parameter logic [SAMPLE_W-1:0] AMPLITUDE = 16'h4000
) (
  input  logic          clk,
  input  logic          reset,
  sfx_tone_gen_if.slave bus
);

  localparam tone_table_t DIV_TABLE  = scale_tone_table(longint'(CLK_HZ));
  localparam logic [7:0]  BEAT_LIMIT = 8'((NUM_BEATS < NUM_TONES) ? NUM_BEATS : NUM_TONES);

  logic [DIV_W-1:0]    div_eff;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    tone_cnt_q, tone_cnt_d;
  logic                tone_active_q, tone_active_d;
  logic [SAMPLE_W-1:0] amp;
  logic [SAMPLE_W-1:0] sample;

  // Disabled or out-of-range beats select a divider of 0, i.e. silence.
  always_comb begin
    div_eff = '0;
    if (bus.en && (bus.ibeat < BEAT_LIMIT)) begin
      div_eff = DIV_TABLE[bus.ibeat[BEAT_IDX_W-1:0]];
    end
  end

  // div_q remembers last clk's divider so a beat change restarts the phase.
  always_comb begin
    div_d         = div_eff;
    tone_active_d = (div_eff != '0);
    tone_cnt_d    = tone_cnt_q + DIV_W'(1);
    if ((div_eff == '0) || (div_eff != div_q) || (tone_cnt_q >= div_eff - DIV_W'(1))) begin
      tone_cnt_d = '0;
    end
  end

  // First half of the period is +amp, second half -amp.
  always_comb begin
    amp = '0;
    if (bus.volume != 3'd0) begin
      amp = AMPLITUDE >> (3'd7 - bus.volume);
    end
    sample = '0;
    if (div_eff != '0) begin
      sample = (tone_cnt_q < (div_eff >> 1)) ? amp : (~amp + SAMPLE_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      tone_cnt_q    <= '0;
      tone_active_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      tone_cnt_q    <= tone_cnt_d;
      tone_active_q <= tone_active_d;
    end
  end

  assign bus.tone_active = tone_active_q;

  i2s_serializer u_serializer (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample),
    .audio_mclk (bus.audio_mclk),
    .audio_lrck (bus.audio_lrck),
    .audio_sck  (bus.audio_sck),
    .audio_sdin (bus.audio_sdin)
  );

endmodule
